// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy vertical-position engine.
package enemy_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FLY  = 1'b1
  } ch_state_e;

  localparam logic [1:0] RATE_SEL_SLOW  = 2'b00;
  localparam logic [1:0] RATE_SEL_MID   = 2'b01;
  localparam logic [1:0] RATE_SEL_QUICK = 2'b10;
  localparam logic [1:0] RATE_SEL_FAST  = 2'b11;

  // Bits needed to hold a count of 0..n simultaneous events.
  function automatic int unsigned popcnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/enemy_y_tracker_if.sv
// Control/status bundle between the spawn/collision logic and the tracker.
interface enemy_y_tracker_if #(
  parameter int unsigned N_CH  = 10,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned ESC_W = 8
);
  logic                  move_en;
  logic [1:0]            flying_rate;
  logic [N_CH-1:0]       spawn;
  logic [N_CH-1:0]       destroy;
  logic [N_CH*Y_W-1:0]   y_flat;
  logic [N_CH-1:0]       active;
  logic [N_CH-1:0]       touch_edge;
  logic [ESC_W-1:0]      escape_cnt;

  modport master (
    output move_en, flying_rate, spawn, destroy,
    input  y_flat, active, touch_edge, escape_cnt
  );

  modport slave (
    input  move_en, flying_rate, spawn, destroy,
    output y_flat, active, touch_edge, escape_cnt
  );
endinterface

// File: rtl/enemy_y_channel.sv
// One enemy channel: IDLE/FLY state, y coordinate and edge-touch pulse.
module enemy_y_channel
  import enemy_pkg::*;
#(
  parameter int unsigned Y_W   = 8,
  parameter int unsigned Y_MAX = 120
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tick,
  input  logic           spawn,
  input  logic           destroy,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           touch_edge,
  output logic           touch_c
);

  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_MAX - 1);
  localparam logic [Y_W-1:0] Y_EDGE = Y_W'(Y_MAX);

  ch_state_e      state_q, state_d;
  logic [Y_W-1:0] y_d;
  logic           touch_d;
  logic           active_d;

  // State, coordinate and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      y          <= '0;
      active     <= 1'b0;
      touch_edge <= 1'b0;
    end else begin
      state_q    <= state_d;
      y          <= y_d;
      active     <= active_d;
      touch_edge <= touch_d;
    end
  end

  // Next state: destroy beats an edge-reaching tick, which beats a plain step.
  always_comb begin
    state_d = state_q;
    y_d     = y;
    touch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (spawn) begin
          state_d = ST_FLY;
          y_d     = '0;
        end
      end
      ST_FLY: begin
        if (destroy) begin
          state_d = ST_IDLE;
          y_d     = '0;
        end else if (tick) begin
          if (y == Y_LAST) begin
            state_d = ST_IDLE;
            y_d     = Y_EDGE;
            touch_d = 1'b1;
          end else begin
            y_d = y + Y_W'(1);
          end
        end
      end
    endcase
    active_d = (state_d == ST_FLY);
  end

  assign touch_c = touch_d;

endmodule

// File: rtl/enemy_y_tracker.sv
// Shared move-tick divider, N_CH enemy channels and saturating escape counter.
module enemy_y_tracker
  import enemy_pkg::*;
#(
  parameter int unsigned N_CH  = 10,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned Y_MAX = 120,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned RATE0 = 12499999,
  parameter int unsigned RATE1 = 6499999,
  parameter int unsigned RATE2 = 3999999,
  parameter int unsigned RATE3 = 1999999,
  parameter int unsigned ESC_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  enemy_y_tracker_if.slave   bus
);

  localparam int unsigned PC_W  = popcnt_width(N_CH);
  localparam int unsigned SUM_W = ((ESC_W > PC_W) ? ESC_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] ESC_SAT = SUM_W'({ESC_W{1'b1}});

  logic [CNT_W-1:0]      div_q;
  logic [CNT_W-1:0]      reload_c;
  logic                  tick_c;
  logic [N_CH-1:0]       touch_c;
  logic [PC_W-1:0]       pop_c;
  logic [SUM_W-1:0]      esc_sum_c;
  logic [ESC_W-1:0]      esc_d;
  logic [ESC_W-1:0]      esc_q;
  logic [N_CH*Y_W-1:0]   y_flat_q;
  logic [N_CH-1:0]       active_q;
  logic [N_CH-1:0]       touch_q;

  // Reload value for the currently selected speed.
  always_comb begin
    reload_c = CNT_W'(RATE0);
    case (bus.flying_rate)
      RATE_SEL_SLOW:  reload_c = CNT_W'(RATE0);
      RATE_SEL_MID:   reload_c = CNT_W'(RATE1);
      RATE_SEL_QUICK: reload_c = CNT_W'(RATE2);
      RATE_SEL_FAST:  reload_c = CNT_W'(RATE3);
    endcase
  end

  // Down-counter; rate is only re-sampled at reload so a live countdown is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= reload_c;
    end else if (bus.move_en) begin
      div_q <= (div_q == '0) ? reload_c : div_q - CNT_W'(1);
    end
  end

  assign tick_c = bus.move_en && (div_q == '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    enemy_y_channel #(
      .Y_W   (Y_W),
      .Y_MAX (Y_MAX)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick_c),
      .spawn      (bus.spawn[i]),
      .destroy    (bus.destroy[i]),
      .y          (y_flat_q[i*Y_W +: Y_W]),
      .active     (active_q[i]),
      .touch_edge (touch_q[i]),
      .touch_c    (touch_c[i])
    );
  end

  // Count of channels touching the edge on this edge.
  always_comb begin
    pop_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_c = pop_c + PC_W'(touch_c[i]);
    end
  end

  // Saturating accumulation of escapes.
  always_comb begin
    esc_sum_c = SUM_W'(esc_q) + SUM_W'(pop_c);
    esc_d     = (esc_sum_c > ESC_SAT) ? {ESC_W{1'b1}} : esc_sum_c[ESC_W-1:0];
  end

  // Escape counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      esc_q <= '0;
    end else begin
      esc_q <= esc_d;
    end
  end

  assign bus.y_flat     = y_flat_q;
  assign bus.active     = active_q;
  assign bus.touch_edge = touch_q;
  assign bus.escape_cnt = esc_q;

endmodule

// File: tb/tb_enemy_y_tracker.sv
// Randomised and directed bench for enemy_y_tracker against a behavioural model.
module tb_enemy_y_tracker;

  localparam int N     = 4;
  localparam int YW    = 8;
  localparam int YMAX  = 5;
  localparam int EW    = 3;
  localparam int ESC_MAX = 7;
  localparam int RATES [4] = '{7, 5, 3, 1};

  logic clk = 1'b0;
  logic reset_n;

  enemy_y_tracker_if #(.N_CH(N), .Y_W(YW), .ESC_W(EW)) bus ();

  enemy_y_tracker #(
    .N_CH(N), .Y_W(YW), .Y_MAX(YMAX), .CNT_W(24),
    .RATE0(7), .RATE1(5), .RATE2(3), .RATE3(1), .ESC_W(EW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: divider countdown, per-channel flight flag/height, escape total.
  int mm;
  bit mfly [N];
  int my   [N];
  bit mtouch [N];
  int mesc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rn, input bit me, input logic [1:0] rate,
                      input logic [N-1:0] sp, input logic [N-1:0] de);
    bit tick;
    int hits;
    logic [N*YW-1:0] ey;
    logic [N-1:0] ea, et;
    reset_n         = rn;
    bus.move_en     = me;
    bus.flying_rate = rate;
    bus.spawn       = sp;
    bus.destroy     = de;
    if (!rn) begin
      mm = RATES[rate];
      for (int c = 0; c < N; c++) begin
        mfly[c] = 0; my[c] = 0; mtouch[c] = 0;
      end
      mesc = 0;
    end else begin
      tick = me && (mm == 0);
      hits = 0;
      for (int c = 0; c < N; c++) begin
        mtouch[c] = 0;
        if (!mfly[c]) begin
          if (sp[c]) begin mfly[c] = 1; my[c] = 0; end
        end else if (de[c]) begin
          mfly[c] = 0; my[c] = 0;
        end else if (tick) begin
          my[c] = my[c] + 1;
          if (my[c] == YMAX) begin
            mfly[c] = 0; mtouch[c] = 1; hits++;
          end
        end
      end
      mesc = (mesc + hits > ESC_MAX) ? ESC_MAX : mesc + hits;
      if (me) mm = (mm == 0) ? RATES[rate] : mm - 1;
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      ey[c*YW +: YW] = YW'(my[c]);
      ea[c] = mfly[c];
      et[c] = mtouch[c];
    end
    check_eq("y_flat", 64'(bus.y_flat), 64'(ey));
    check_eq("active", 64'(bus.active), 64'(ea));
    check_eq("touch_edge", 64'(bus.touch_edge), 64'(et));
    check_eq("escape_cnt", 64'(bus.escape_cnt), 64'(mesc));
  endtask

  task automatic idle_steps(input int n, input bit me, input logic [1:0] rate);
    for (int k = 0; k < n; k++) step(1, me, rate, '0, '0);
  endtask

  initial begin
    bit found;
    int esc_before;
    reset_n = 1'b0;
    bus.move_en = 1'b0;
    bus.flying_rate = 2'b00;
    bus.spawn = '0;
    bus.destroy = '0;
    @(negedge clk);

    // 1: single channel flight to the edge at the fastest rate.
    step(0, 1, 2'b11, '0, '0);
    step(0, 1, 2'b11, '0, '0);
    check_eq("rst_y", 64'(bus.y_flat), 64'd0);
    check_eq("rst_esc", 64'(bus.escape_cnt), 64'd0);
    step(1, 1, 2'b11, 4'b0001, '0);
    check_eq("t1_active", 64'(bus.active[0]), 64'd1);
    idle_steps(14, 1, 2'b11);
    check_eq("t1_esc", 64'(bus.escape_cnt), 64'd1);
    check_eq("t1_y_edge", 64'(bus.y_flat[YW-1:0]), 64'(YMAX));

    // 2: destroy at y=2 coinciding with a tick.
    step(1, 1, 2'b11, 4'b0010, '0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mfly[1] && my[1] == 2 && mm == 0) begin
        esc_before = mesc;
        step(1, 1, 2'b11, '0, 4'b0010);
        check_eq("t2_no_touch", 64'(bus.touch_edge[1]), 64'd0);
        check_eq("t2_esc_hold", 64'(bus.escape_cnt), 64'(esc_before));
        found = 1;
      end else begin
        step(1, 1, 2'b11, '0, '0);
      end
    end
    check_eq("t2_reached", 64'(found), 64'd1);

    // 3: pause mid-flight, then resume.
    step(1, 1, 2'b01, 4'b0001, '0);
    idle_steps(3, 1, 2'b01);
    idle_steps(20, 0, 2'b01);
    idle_steps(20, 1, 2'b01);

    // 4: three channels touch together until the counter saturates.
    for (int r = 0; r < 3; r++) begin
      step(1, 1, 2'b11, 4'b1101, '0);
      idle_steps(14, 1, 2'b11);
    end
    check_eq("t4_sat", 64'(bus.escape_cnt), 64'(ESC_MAX));

    // 5: rate change in the middle of a slow countdown.
    step(1, 1, 2'b00, 4'b0100, '0);
    idle_steps(3, 1, 2'b00);
    idle_steps(20, 1, 2'b11);

    // 6: reset while flying with escape_cnt = 4; spawn held through reset.
    step(0, 1, 2'b11, '0, '0);
    step(1, 1, 2'b11, 4'b1111, '0);
    idle_steps(12, 1, 2'b11);
    check_eq("t6_esc4", 64'(bus.escape_cnt), 64'd4);
    step(1, 1, 2'b11, 4'b0011, '0);
    idle_steps(3, 1, 2'b11);
    step(0, 1, 2'b11, 4'b1111, '0);
    check_eq("t6_rst_active", 64'(bus.active), 64'd0);
    step(1, 1, 2'b11, 4'b1111, '0);
    check_eq("t6_spawn_after_rst", 64'(bus.active), 64'hF);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) != 0,
           2'($urandom_range(0, 3)),
           4'($urandom & $urandom),
           4'($urandom & $urandom & $urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
